// File: rtl/settings_controller.sv
// Volume / palette settings controller: turns button levels into step events with
// press-and-hold auto-repeat, and supports keep (A) or revert-to-entry (B) on exit.
module settings_controller #(
    parameter int VOL_BITS      = 3,
    parameter int VOL_DEFAULT   = 4,
    parameter int NUM_PAL       = 4,
    parameter int HOLD_DELAY    = 12500000,
    parameter int REPEAT_PERIOD = 2500000,
    localparam int PW           = $clog2(NUM_PAL)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [2:0]          state,
    input  logic [7:0]          buttons,
    output logic [VOL_BITS-1:0] volume,
    output logic [PW-1:0]       palette,
    output logic                back,
    output logic                changed
);

    localparam int MAX_DLY = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(MAX_DLY) + 1;
    localparam logic [VOL_BITS-1:0] VOL_MAX  = '1;
    localparam logic [PW-1:0]       PAL_MAX  = PW'(NUM_PAL - 1);
    localparam logic [CW-1:0]       HOLD_END = CW'(HOLD_DELAY - 1);
    localparam logic [CW-1:0]       REP_END  = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} fsm_t;

    fsm_t                fsm_reg, fsm_next;
    logic                dir_reg, dir_next;       // 1 = increment direction
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [7:0]          prev_buttons_reg;
    logic                prev_active_reg;
    logic [VOL_BITS-1:0] volume_reg, volume_next, snap_vol_reg, snap_vol_next;
    logic [PW-1:0]       palette_reg, palette_next, snap_pal_reg, snap_pal_next;
    logic                back_reg, back_next, changed_reg, changed_next;

    logic       is_vol, active, entry, inc, dec, inc_rise, dec_rise;
    logic       press_up, press_dn, a_rise, b_rise, dir_held;
    logic       step_en, step_up;
    logic [7:0] rise;

    assign is_vol   = (state == 3'b101);
    assign active   = en & (is_vol | (state == 3'b110));
    assign entry    = active & ~prev_active_reg;
    assign rise     = buttons & ~prev_buttons_reg;
    assign inc      = buttons[0] | buttons[3];
    assign dec      = buttons[1] | buttons[2];
    assign inc_rise = inc & ~(prev_buttons_reg[0] | prev_buttons_reg[3]);
    assign dec_rise = dec & ~(prev_buttons_reg[1] | prev_buttons_reg[2]);
    assign press_up = inc_rise & ~dec;
    assign press_dn = dec_rise & ~inc;
    assign a_rise   = rise[4];
    assign b_rise   = rise[5];
    assign dir_held = dir_reg ? inc : dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg          <= IDLE;
            dir_reg          <= 1'b0;
            cnt_reg          <= '0;
            prev_buttons_reg <= '0;
            prev_active_reg  <= 1'b0;
            volume_reg       <= VOL_BITS'(VOL_DEFAULT);
            snap_vol_reg     <= VOL_BITS'(VOL_DEFAULT);
            palette_reg      <= '0;
            snap_pal_reg     <= '0;
            back_reg         <= 1'b0;
            changed_reg      <= 1'b0;
        end else begin
            fsm_reg          <= fsm_next;
            dir_reg          <= dir_next;
            cnt_reg          <= cnt_next;
            prev_buttons_reg <= buttons;
            prev_active_reg  <= active;
            volume_reg       <= volume_next;
            snap_vol_reg     <= snap_vol_next;
            palette_reg      <= palette_next;
            snap_pal_reg     <= snap_pal_next;
            back_reg         <= back_next;
            changed_reg      <= changed_next;
        end
    end

    always_comb begin
        fsm_next      = fsm_reg;
        dir_next      = dir_reg;
        cnt_next      = cnt_reg;
        volume_next   = volume_reg;
        palette_next  = palette_reg;
        snap_vol_next = snap_vol_reg;
        snap_pal_next = snap_pal_reg;
        back_next     = 1'b0;
        changed_next  = 1'b0;
        step_en       = 1'b0;
        step_up       = 1'b0;

        if (!active || entry) begin
            fsm_next = IDLE;
            cnt_next = '0;
            if (entry) begin
                snap_vol_next = volume_reg;
                snap_pal_next = palette_reg;
            end
        end else if (b_rise || a_rise) begin
            back_next = 1'b1;
            fsm_next  = IDLE;
            cnt_next  = '0;
            if (b_rise) begin
                if (is_vol) volume_next  = snap_vol_reg;
                else        palette_next = snap_pal_reg;
            end
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (press_up || press_dn) begin
                        step_en  = 1'b1;
                        step_up  = press_up;
                        dir_next = press_up;
                        cnt_next = '0;
                        fsm_next = HOLD;
                    end
                end
                default: begin
                    // An opposite-direction press after releasing the old one restarts the hold.
                    if (!dir_held && (dir_reg ? press_dn : press_up)) begin
                        step_en  = 1'b1;
                        step_up  = ~dir_reg;
                        dir_next = ~dir_reg;
                        cnt_next = '0;
                        fsm_next = HOLD;
                    end else if (!dir_held || (inc && dec)) begin
                        fsm_next = IDLE;
                        cnt_next = '0;
                    end else if (cnt_reg == ((fsm_reg == HOLD) ? HOLD_END : REP_END)) begin
                        step_en  = 1'b1;
                        step_up  = dir_reg;
                        cnt_next = '0;
                        fsm_next = REPEAT;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            endcase
        end

        if (step_en) begin
            if (is_vol) begin
                if (step_up && volume_reg != VOL_MAX) begin
                    volume_next  = volume_reg + 1'b1;
                    changed_next = 1'b1;
                end else if (!step_up && volume_reg != '0) begin
                    volume_next  = volume_reg - 1'b1;
                    changed_next = 1'b1;
                end
            end else begin
                if (step_up) palette_next = (palette_reg == PAL_MAX) ? '0 : palette_reg + 1'b1;
                else         palette_next = (palette_reg == '0) ? PAL_MAX : palette_reg - 1'b1;
                changed_next = 1'b1;
            end
        end
    end

    assign volume  = volume_reg;
    assign palette = palette_reg;
    assign back    = back_reg;
    assign changed = changed_reg;

endmodule

// File: tb/tb_settings_controller.sv
// Directed bench for settings_controller with short hold/repeat timing.
module tb_settings_controller;

    localparam logic [7:0] UP = 8'h01, DOWN = 8'h02, LEFT = 8'h04, RIGHT = 8'h08;
    localparam logic [7:0] BA = 8'h10, BB = 8'h20, NONE = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [2:0] state = 3'b000;
    logic [7:0] buttons = 8'h00;
    logic [2:0] volume;
    logic [1:0] palette;
    logic       back, changed;

    int total = 0;
    int bad   = 0;
    int pulses;

    settings_controller #(
        .VOL_BITS(3), .VOL_DEFAULT(4), .NUM_PAL(4), .HOLD_DELAY(4), .REPEAT_PERIOD(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .state(state), .buttons(buttons),
        .volume(volume), .palette(palette), .back(back), .changed(changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        buttons = NONE;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        check("rst_vol", volume, 4);
        check("rst_pal", palette, 0);
        check("rst_back", back, 0);
        check("rst_chg", changed, 0);
        rst = 1'b0;

        // Two single Up presses in volume
        state = 3'b101; tick();
        buttons = UP; tick();
        check("up1_vol", volume, 5);
        check("up1_chg", changed, 1);
        buttons = NONE; tick();
        check("up1_chg_low", changed, 0);
        buttons = UP; tick();
        check("up2_vol", volume, 6);
        check("up2_chg", changed, 1);
        check("up2_back", back, 0);
        buttons = NONE; tick();

        // Hold Up for 20 cycles: steps at 0, 4, 6 then saturate
        do_reset();
        tick();
        pulses = 0;
        buttons = UP;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (changed) pulses++;
            if (i == 1) check("hold_t1", volume, 5);
            if (i == 4) check("hold_t4", volume, 5);
            if (i == 5) check("hold_t5", volume, 6);
            if (i == 6) check("hold_t6", volume, 6);
            if (i == 7) check("hold_t7", volume, 7);
        end
        check("hold_sat", volume, 7);
        check("hold_pulses", pulses, 3);
        buttons = NONE;

        // Palette wrap in both directions, Up+Down together ignored
        do_reset();
        state = 3'b110; tick();
        buttons = LEFT; tick();
        check("pal_left", palette, 3);
        buttons = NONE; tick();
        buttons = RIGHT; tick();
        check("pal_right", palette, 0);
        buttons = NONE; tick();
        pulses = 0;
        buttons = UP | DOWN;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (changed) pulses++;
        end
        check("pal_both", palette, 0);
        check("pal_both_chg", pulses, 0);
        buttons = NONE; tick();

        // B reverts to entry value, A keeps
        do_reset();
        state = 3'b101; tick();
        buttons = UP; tick(); buttons = NONE; tick();
        buttons = UP; tick(); buttons = NONE; tick();
        check("pre_b_vol", volume, 6);
        buttons = BB; tick();
        check("b_vol", volume, 4);
        check("b_back", back, 1);
        buttons = NONE; tick();
        check("b_back_low", back, 0);
        state = 3'b000; tick();
        state = 3'b101; tick();
        buttons = UP; tick(); buttons = NONE; tick();
        buttons = BA; tick();
        check("a_vol", volume, 5);
        check("a_back", back, 1);
        buttons = NONE; tick();
        check("a_back_low", back, 0);

        // Up held across entry: no step until re-pressed; A+B together reverts
        state = 3'b000; tick();
        buttons = UP; tick();
        state = 3'b101; tick(); tick(); tick();
        check("held_entry", volume, 5);
        buttons = NONE; tick();
        buttons = UP; tick();
        check("repress", volume, 6);
        buttons = NONE; tick();
        buttons = BA | BB; tick();
        check("ab_vol", volume, 5);
        check("ab_back", back, 1);
        buttons = NONE; tick();

        // Down held 5 cycles then async reset mid-repeat
        buttons = DOWN;
        for (int i = 0; i < 5; i++) tick();
        check("down_vol", volume, 3);
        #2 rst = 1'b1;
        #1;
        check("arst_vol", volume, 4);
        check("arst_pal", palette, 0);
        check("arst_chg", changed, 0);
        check("arst_back", back, 0);
        tick();
        buttons = NONE;
        rst = 1'b0;
        tick();
        check("post_rst_chg", changed, 0);

        // Disabled: presses ignored
        en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            buttons = UP; tick();
            if (changed || back) pulses++;
            buttons = BB; tick();
            if (changed || back) pulses++;
        end
        check("dis_vol", volume, 4);
        check("dis_pulses", pulses, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
